// File: rtl/alu_serial_seq_if.sv
// Start/done request bus between an issuing unit and the bit-serial ALU sequencer.
// The master drives operands and control; the slave returns the result and flags.
interface alu_serial_seq_if #(
    parameter int unsigned W = 32
);
    logic         start_i;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic [3:0]   ALU_control_i;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         cout_o;
    logic         overflow_o;
    logic         busy_o;
    logic         done_o;

    modport master (
        output start_i, src1_i, src2_i, ALU_control_i,
        input  result_o, zero_o, cout_o, overflow_o, busy_o, done_o
    );

    modport slave (
        input  start_i, src1_i, src2_i, ALU_control_i,
        output result_o, zero_o, cout_o, overflow_o, busy_o, done_o
    );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: evaluates one 1-bit ALU slice per cycle, LSB first, with a
// registered ripple carry, then publishes the W-bit result and flags for one DONE cycle.
module alu_serial_seq #(
    parameter int unsigned W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_serial_seq_if.slave   bus
);
    localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    src1_q;
    logic [W-1:0]    src2_q;
    logic [3:0]      ctrl_q;
    logic [IDX_W-1:0] idx_q;
    logic            carry_q;
    logic [W-1:0]    work_q;

    logic [W-1:0]    result_q;
    logic            zero_q;
    logic            cout_q;
    logic            overflow_q;
    logic            busy_q;
    logic            done_q;

    logic            a_bit_c;
    logic            b_bit_c;
    logic            sum_c;
    logic            carry_next_c;
    logic            slice_c;
    logic [W-1:0]    final_c;

    // One ALU slice on the current bit, operands conditionally inverted
    always_comb begin
        a_bit_c      = src1_q[idx_q] ^ ctrl_q[3];
        b_bit_c      = src2_q[idx_q] ^ ctrl_q[2];
        sum_c        = a_bit_c ^ b_bit_c ^ carry_q;
        carry_next_c = (a_bit_c & b_bit_c) | (a_bit_c & carry_q) | (b_bit_c & carry_q);
        slice_c      = 1'b0;
        case (ctrl_q[1:0])
            2'd0:    slice_c = a_bit_c & b_bit_c;
            2'd1:    slice_c = a_bit_c | b_bit_c;
            2'd2:    slice_c = sum_c;
            default: slice_c = 1'b0;
        endcase
    end

    // Full word as it stands once the MSB slice is written; SLT keeps only the MSB sum
    always_comb begin
        final_c         = work_q;
        final_c[W-1]    = slice_c;
        if (ctrl_q[1:0] == 2'd3) begin
            final_c = {{(W-1){1'b0}}, sum_c};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            src1_q     <= '0;
            src2_q     <= '0;
            ctrl_q     <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            work_q     <= '0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        src1_q  <= bus.src1_i;
                        src2_q  <= bus.src2_i;
                        ctrl_q  <= bus.ALU_control_i;
                        idx_q   <= '0;
                        carry_q <= bus.ALU_control_i[2];
                        work_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    work_q[idx_q] <= slice_c;
                    carry_q       <= carry_next_c;
                    if (idx_q == LAST_IDX) begin
                        // Publish at the last slice so outputs are valid during DONE
                        result_q   <= final_c;
                        zero_q     <= (final_c == '0);
                        cout_q     <= carry_next_c;
                        overflow_q <= carry_q ^ carry_next_c;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.result_o   = result_q;
    assign bus.zero_o     = zero_q;
    assign bus.cout_o     = cout_q;
    assign bus.overflow_o = overflow_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial ALU sequencer: accepts two W-bit operands plus a 4-bit ALU control word.
- Drives one internal 1-bit ALU slice per cycle, LSB first, carrying the ripple carry in a register.
- Assembles the W-bit result, zero, carry-out and overflow flags.
- Serves as the area-minimal, multi-cycle companion to the parallel ripple ALU; the issuing side waits on a start/done handshake.

Parameters:
- W, 32, operand/result width in bits (W >= 2)

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous reset, active-low
- start_i  input  1  request; sampled only in IDLE
- src1_i  input  W  operand A; captured on accepted start
- src2_i  input  W  operand B; captured on accepted start
- ALU_control_i  input  4  {A_invert, B_invert, operation[1:0]}; captured on accepted start
- result_o  output  W  final result; held until next accepted start
- zero_o  output  1  result_o == 0
- cout_o  output  1  carry out of MSB slice
- overflow_o  output  1  carry into MSB XOR carry out of MSB
- busy_o  output  1  high in RUN and DONE
- done_o  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (rst_i low, any time, asynchronous): state = IDLE; result_o = 0, zero_o = 1, cout_o = 0, overflow_o = 0, busy_o = 0, done_o = 0; captured operands, bit index and carry register cleared. A reset mid-operation abandons the operation with no done pulse.
- Per-bit slice function, applied to bit i:
  - a = A[i] ^ A_invert; b = B[i] ^ B_invert.
  - operation 0 = a&b; 1 = a|b; 2 = a^b^c.
  - operation 3 (less) writes 0 during RUN.
  - Carry next = majority(a, b, c).
- Encodings used: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- State machine:
  - IDLE:
    - start_i high: capture src1_i, src2_i, ALU_control_i; bit index = 0; carry register = B_invert; clear working result; go to RUN.
    - start_i low: stay in IDLE; outputs unchanged.
  - RUN:
    - Each cycle evaluate bit index i, write working result bit i, update carry, increment index.
    - At i = W-1, record carry-in to MSB and carry-out, then go to DONE.
    - RUN lasts exactly W cycles.
  - DONE (one cycle):
    - Publish result_o, zero_o, cout_o, overflow_o, all registered.
    - For operation 3, result_o = {W-1 zeros, set}, where set = sum bit of MSB slice (a^b^c at i = W-1). There is no overflow correction, matching the parallel ALU's set/less wiring.
    - done_o = 1; then go to IDLE.
- Latency: start accepted at edge 0 -> done_o high during cycle W+1; outputs valid from that cycle and stable until the DONE of the next operation.
- start_i while busy_o = 1: ignored, with no queueing. start_i held high in IDLE back-to-back restarts on the first IDLE cycle.
- Flags are updated for every operation: cout_o/overflow_o reflect the carry chain even for AND/OR/NOR (same as the parallel ALU).
- Inputs may change freely after capture; they have no effect until the next accepted start.

Test Plan:
- W=32, ADD 0x7FFFFFFF + 0x00000001 -> done_o pulses exactly 33 cycles after start edge; result_o=0x80000000, overflow_o=1, cout_o=0, zero_o=0.
- SUB 0x00000005 - 0x00000005 -> result_o=0, zero_o=1, cout_o=1, overflow_o=0.
- SLT:
  - 3 vs 7 -> result_o=0x00000001.
  - 7 vs 3 -> result_o=0x00000000, zero_o=1.
- NOR 0xF0F0F0F0, 0x0F0F0000 -> result_o=0x00000F0F. AND 0xFFFF0000, 0x0F0F0F0F -> 0x0F0F0000. OR same operands -> 0xFFFF0F0F.
- Start ADD 1+1; pulse start_i with SUB operands at RUN cycle 5 -> ignored, result_o=0x00000002 at DONE. Then immediately accepted start on next IDLE cycle completes correctly.
- Drop rst_i low mid-RUN at cycle 10 -> outputs immediately reset (result_o=0, zero_o=1, busy_o=0), no done_o. After release, new ADD 0xFFFFFFFF+1 -> result_o=0, cout_o=1, zero_o=1.
